// File: rtl/rf_pkg.sv
// Shared types and constants for the sample FIFO reader.
package rf_pkg;

  localparam int SKID_DEPTH   = 4;
  localparam int SKID_PTR_BIT = 2;
  localparam int SKID_CNT_BIT = 3;

  typedef enum logic [2:0] {
    IDLE,
    MARK,
    STREAM,
    DRAIN,
    REWIND,
    SETTLE,
    FLUSH
  } rf_state_e;

endpackage

// File: rtl/sample_fifo_reader_if.sv
// Job control, FIFO read port and downstream stream of the sample FIFO reader.
interface sample_fifo_reader_if #(
  parameter int FIFO_WIDTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int PASS_BIT       = 8
);

  logic                      i_start;
  logic                      i_abort;
  logic [FIFO_DEPTH_BIT:0]   i_num_samples;
  logic [PASS_BIT-1:0]       i_num_passes;

  logic                      o_pop;
  logic                      o_mark_read_rst;
  logic                      o_read_rst;
  logic [FIFO_WIDTH-1:0]     i_front;
  logic                      i_vld;
  logic                      i_empty;

  logic [FIFO_WIDTH-1:0]     o_data;
  logic                      o_data_vld;
  logic                      i_data_rdy;
  logic                      o_last;
  logic [PASS_BIT-1:0]       o_pass_idx;
  logic                      o_busy;
  logic                      o_done;

  // The reader drives FIFO controls and the output stream.
  modport master (
    input  i_start, i_abort, i_num_samples, i_num_passes,
    input  i_front, i_vld, i_empty, i_data_rdy,
    output o_pop, o_mark_read_rst, o_read_rst,
    output o_data, o_data_vld, o_last, o_pass_idx, o_busy, o_done
  );

  // The environment: job requester, FIFO and downstream consumer.
  modport slave (
    output i_start, i_abort, i_num_samples, i_num_passes,
    output i_front, i_vld, i_empty, i_data_rdy,
    input  o_pop, o_mark_read_rst, o_read_rst,
    input  o_data, o_data_vld, o_last, o_pass_idx, o_busy, o_done
  );

endinterface

// File: rtl/skid_fifo4.sv
// Four-entry registered FIFO catching FIFO read returns ahead of the output stream.
module skid_fifo4
  import rf_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    wr_i,
  input  logic [WIDTH-1:0]        wdata_i,
  input  logic                    rd_i,
  output logic [WIDTH-1:0]        rdata_o,
  output logic                    vld_o,
  output logic [SKID_CNT_BIT-1:0] count_o
);

  logic [WIDTH-1:0]        mem_q [SKID_DEPTH];
  logic [SKID_PTR_BIT-1:0] wrPtr_q;
  logic [SKID_PTR_BIT-1:0] rdPtr_q;
  logic [SKID_CNT_BIT-1:0] count_q;
  logic                    doWr;
  logic                    doRd;

  assign doWr    = wr_i && (count_q != SKID_CNT_BIT'(SKID_DEPTH));
  assign doRd    = rd_i && (count_q != '0);
  assign rdata_o = mem_q[rdPtr_q];
  assign vld_o   = (count_q != '0);
  assign count_o = count_q;

  // Pointer and occupancy tracking; a simultaneous write and read leaves the count alone.
  always_ff @(posedge clk) begin
    if (!rst_n || clr_i) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doWr) wrPtr_q <= wrPtr_q + SKID_PTR_BIT'(1);
      if (doRd) rdPtr_q <= rdPtr_q + SKID_PTR_BIT'(1);
      if (doWr && !doRd) count_q <= count_q + SKID_CNT_BIT'(1);
      else if (!doWr && doRd) count_q <= count_q - SKID_CNT_BIT'(1);
    end
  end

  // Data storage needs no reset; the occupancy count guards every read.
  always_ff @(posedge clk) begin
    if (doWr) mem_q[wrPtr_q] <= wdata_i;
  end

endmodule

// File: rtl/sample_fifo_reader.sv
// Reads a job of samples from a latency-3 FIFO, replaying it for several passes.
module sample_fifo_reader
  import rf_pkg::*;
#(
  parameter int FIFO_WIDTH     = 16,
  parameter int FIFO_DEPTH_BIT = 4,
  parameter int READ_LAT       = 3,
  parameter int PASS_BIT       = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  sample_fifo_reader_if.master bus
);

  localparam int CNT_BIT = FIFO_DEPTH_BIT + 1;

  if (READ_LAT < 1) begin : g_latCheck
    $error("sample_fifo_reader: READ_LAT must be at least 1");
  end

  rf_state_e               state_q, state_d;
  logic [CNT_BIT-1:0]      numSamples_q, numSamples_d;
  logic [PASS_BIT-1:0]     numPasses_q, numPasses_d;
  logic [PASS_BIT-1:0]     passIdx_q, passIdx_d;
  logic [CNT_BIT-1:0]      issued_q, issued_d;
  logic [CNT_BIT-1:0]      delivered_q, delivered_d;
  logic [SKID_CNT_BIT-1:0] inFlight_q, inFlight_d;
  logic                    done_q, done_d;

  logic [FIFO_WIDTH-1:0]   bufData;
  logic                    bufVld;
  logic [SKID_CNT_BIT-1:0] bufCount;
  logic                    dataVld;
  logic                    handshake;
  logic                    room;
  logic                    pop;
  logic                    retire;
  logic                    skidWr;
  logic [CNT_BIT-1:0]      deliveredNext;

  assign dataVld       = bufVld && (state_q != FLUSH);
  assign handshake     = dataVld && bus.i_data_rdy;
  assign room          = ({1'b0, inFlight_q} + {1'b0, bufCount}) < 4'(SKID_DEPTH);
  assign pop           = (state_q == STREAM) && !bus.i_abort && !bus.i_empty &&
                         (issued_q < numSamples_q) && room;
  assign retire        = bus.i_vld && (inFlight_q != '0);
  assign skidWr        = bus.i_vld && ((state_q == STREAM) || (state_q == DRAIN)) && !bus.i_abort;
  assign deliveredNext = delivered_q + CNT_BIT'(handshake);

  skid_fifo4 #(
    .WIDTH (FIFO_WIDTH)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (state_q == FLUSH),
    .wr_i    (skidWr),
    .wdata_i (bus.i_front),
    .rd_i    (handshake),
    .rdata_o (bufData),
    .vld_o   (bufVld),
    .count_o (bufCount)
  );

  assign bus.o_pop           = pop;
  assign bus.o_mark_read_rst = (state_q == MARK);
  assign bus.o_read_rst      = (state_q == REWIND);
  assign bus.o_data          = dataVld ? bufData : '0;
  assign bus.o_data_vld      = dataVld;
  assign bus.o_last          = dataVld && ((delivered_q + CNT_BIT'(1)) == numSamples_q);
  assign bus.o_pass_idx      = passIdx_q;
  assign bus.o_busy          = (state_q != IDLE);
  assign bus.o_done          = done_q;

  // Register every piece of job state; reset drops straight back to an empty IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      numSamples_q <= '0;
      numPasses_q  <= '0;
      passIdx_q    <= '0;
      issued_q     <= '0;
      delivered_q  <= '0;
      inFlight_q   <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      numSamples_q <= numSamples_d;
      numPasses_q  <= numPasses_d;
      passIdx_q    <= passIdx_d;
      issued_q     <= issued_d;
      delivered_q  <= delivered_d;
      inFlight_q   <= inFlight_d;
      done_q       <= done_d;
    end
  end

  // Sequence the job through its passes; an abort overrides whatever else this cycle wanted.
  always_comb begin
    state_d      = state_q;
    numSamples_d = numSamples_q;
    numPasses_d  = numPasses_q;
    passIdx_d    = passIdx_q;
    issued_d     = issued_q + CNT_BIT'(pop);
    delivered_d  = deliveredNext;
    inFlight_d   = inFlight_q;
    done_d       = 1'b0;

    if (pop && !retire) inFlight_d = inFlight_q + SKID_CNT_BIT'(1);
    else if (!pop && retire) inFlight_d = inFlight_q - SKID_CNT_BIT'(1);

    case (state_q)
      IDLE: begin
        if (bus.i_start) begin
          numSamples_d = bus.i_num_samples;
          numPasses_d  = bus.i_num_passes;
          passIdx_d    = '0;
          issued_d     = '0;
          delivered_d  = '0;
          if ((bus.i_num_samples == '0) || (bus.i_num_passes == '0)) done_d = 1'b1;
          else state_d = MARK;
        end
      end
      MARK:   state_d = STREAM;
      STREAM: if (issued_q == numSamples_q) state_d = DRAIN;
      DRAIN: begin
        if (deliveredNext == numSamples_q) begin
          if (passIdx_q == numPasses_q - PASS_BIT'(1)) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            passIdx_d = passIdx_q + PASS_BIT'(1);
            state_d   = REWIND;
          end
        end
      end
      REWIND: state_d = SETTLE;
      SETTLE: begin
        issued_d    = '0;
        delivered_d = '0;
        state_d     = STREAM;
      end
      FLUSH:   if (inFlight_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.i_abort && (state_q != IDLE) && (state_q != FLUSH)) begin
      state_d   = FLUSH;
      done_d    = 1'b0;
      passIdx_d = passIdx_q;
    end
  end

endmodule

// File: tb/tb_sample_fifo_reader.sv
// Directed bench for sample_fifo_reader with a latency-3 FIFO model and an output scoreboard.
module tb_sample_fifo_reader;

  localparam int FW  = 16;
  localparam int DB  = 4;
  localparam int CW  = DB + 1;
  localparam int LAT = 3;
  localparam int PB  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sample_fifo_reader_if #(.FIFO_WIDTH(FW), .FIFO_DEPTH_BIT(DB), .PASS_BIT(PB)) bus ();

  sample_fifo_reader #(
    .FIFO_WIDTH     (FW),
    .FIFO_DEPTH_BIT (DB),
    .READ_LAT       (LAT),
    .PASS_BIT       (PB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [FW-1:0] fifoMem [0:31];
  int            wrPtr, rdPtr, markPtr;
  logic          pipeVld  [LAT];
  logic [FW-1:0] pipeData [LAT];

  int popCnt, markCnt, readRstCnt, doneCnt, hsCnt, lastCnt, busyCnt, dataVldCnt;
  int popWhileEmpty, outstanding, maxOutstanding, unstableCnt;
  int cycleNo, lastHsCycle, doneCycle;
  logic          holding;
  logic [FW-1:0] heldData;

  logic [FW-1:0] expQ [$];
  int            expIdx, expPass, curN;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic clearStats();
    popCnt = 0; markCnt = 0; readRstCnt = 0; doneCnt = 0; hsCnt = 0; lastCnt = 0;
    busyCnt = 0; dataVldCnt = 0; popWhileEmpty = 0; outstanding = 0; maxOutstanding = 0;
    unstableCnt = 0; lastHsCycle = -100; doneCycle = -100; holding = 1'b0; heldData = '0;
    expQ.delete(); expIdx = 0; expPass = 0;
  endtask

  task automatic loadFifo(input int n, input logic [FW-1:0] base);
    rdPtr = 0; wrPtr = 0; markPtr = 0;
    for (int i = 0; i < n; i++) fifoMem[i] = base + FW'(i);
    wrPtr = n;
    bus.i_empty = (n == 0);
  endtask

  task automatic pushFifo(input logic [FW-1:0] data);
    fifoMem[wrPtr] = data;
    wrPtr++;
    bus.i_empty = 1'b0;
  endtask

  task automatic expectSamples(input int n, input logic [FW-1:0] base, input int passes);
    curN = n;
    for (int p = 0; p < passes; p++)
      for (int i = 0; i < n; i++) expQ.push_back(base + FW'(i));
  endtask

  task automatic updateModel(input logic sPop, input logic sMark, input logic sRst);
    for (int k = LAT - 1; k > 0; k--) begin
      pipeVld[k]  = pipeVld[k-1];
      pipeData[k] = pipeData[k-1];
    end
    pipeVld[0]  = sPop;
    pipeData[0] = fifoMem[rdPtr];
    if (sPop) rdPtr++;
    if (sMark) markPtr = rdPtr;
    if (sRst) rdPtr = markPtr;
    if (!rst_n) for (int k = 0; k < LAT; k++) pipeVld[k] = 1'b0;
    bus.i_vld   = pipeVld[LAT-1];
    bus.i_front = pipeData[LAT-1];
    bus.i_empty = (rdPtr == wrPtr);
  endtask

  task automatic stepCycle();
    logic          sPop, sMark, sRst;
    logic [FW-1:0] expData;
    @(negedge clk);
    cycleNo++;
    sPop  = bus.o_pop;
    sMark = bus.o_mark_read_rst;
    sRst  = bus.o_read_rst;
    if (sPop) popCnt++;
    if (sPop && bus.i_empty) popWhileEmpty++;
    if (sMark) markCnt++;
    if (sRst) readRstCnt++;
    if (bus.o_done) begin doneCnt++; doneCycle = cycleNo; end
    if (bus.o_busy) busyCnt++;
    if (bus.o_data_vld) dataVldCnt++;
    if (bus.o_data_vld && bus.o_last) lastCnt++;
    if (holding && bus.o_data_vld && (bus.o_data !== heldData)) unstableCnt++;
    holding  = bus.o_data_vld && !bus.i_data_rdy;
    heldData = bus.o_data;
    if (sPop) outstanding++;
    if (bus.o_data_vld && bus.i_data_rdy) begin
      outstanding--;
      hsCnt++;
      lastHsCycle = cycleNo;
      if (expQ.size() == 0) begin
        checkOutput("unexpected_data", 32'(bus.o_data), 32'hFFFF_FFFF);
      end else begin
        expData = expQ.pop_front();
        checkOutput("data", 32'(bus.o_data), 32'(expData));
        checkOutput("last", 32'(bus.o_last), 32'(expIdx == curN - 1));
        checkOutput("pass_idx", 32'(bus.o_pass_idx), 32'(expPass));
        expIdx++;
        if (expIdx == curN) begin expIdx = 0; expPass++; end
      end
    end
    if (outstanding > maxOutstanding) maxOutstanding = outstanding;
    @(posedge clk);
    #1;
    updateModel(sPop, sMark, sRst);
  endtask

  task automatic applyStimulus(input int n, input int passes);
    bus.i_num_samples = CW'(n);
    bus.i_num_passes  = PB'(passes);
    bus.i_start       = 1'b1;
    stepCycle();
    bus.i_start       = 1'b0;
  endtask

  task automatic runUntilDone(input int budget);
    int c;
    c = 0;
    while (doneCnt == 0 && c < budget) begin
      stepCycle();
      c++;
    end
    if (doneCnt == 0) checkOutput("done_timeout", 32'(c), 32'(budget + 1));
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c;
    int popsBefore;
    int returnsLeft;
    bus.i_start = 1'b0; bus.i_abort = 1'b0; bus.i_num_samples = '0; bus.i_num_passes = '0;
    bus.i_front = '0; bus.i_vld = 1'b0; bus.i_empty = 1'b1; bus.i_data_rdy = 1'b1;
    for (int k = 0; k < LAT; k++) begin pipeVld[k] = 1'b0; pipeData[k] = '0; end
    cycleNo = 0;
    clearStats();
    loadFifo(0, '0);

    // Reset state
    rst_n = 1'b0;
    repeat (3) stepCycle();
    checkOutput("reset_ctrl", 32'({bus.o_pop, bus.o_mark_read_rst, bus.o_read_rst, bus.o_data_vld,
                                   bus.o_last, bus.o_busy, bus.o_done}), 32'd0);
    checkOutput("reset_data", 32'(bus.o_data), 32'd0);
    checkOutput("reset_pass", 32'(bus.o_pass_idx), 32'd0);
    rst_n = 1'b1;
    stepCycle();

    // Single pass of five samples
    $display("[TB] single pass");
    clearStats();
    loadFifo(5, 16'hA000);
    expectSamples(5, 16'hA000, 1);
    applyStimulus(5, 1);
    runUntilDone(100);
    repeat (4) stepCycle();
    checkOutput("p1_marks", 32'(markCnt), 32'd1);
    checkOutput("p1_pops", 32'(popCnt), 32'd5);
    checkOutput("p1_outputs", 32'(hsCnt), 32'd5);
    checkOutput("p1_lasts", 32'(lastCnt), 32'd1);
    checkOutput("p1_done_cnt", 32'(doneCnt), 32'd1);
    checkOutput("p1_done_delay", 32'(doneCycle - lastHsCycle), 32'd1);
    checkOutput("p1_read_rst", 32'(readRstCnt), 32'd0);
    checkOutput("p1_busy_after", 32'(bus.o_busy), 32'd0);

    // Three passes over the same data
    $display("[TB] three passes");
    clearStats();
    loadFifo(5, 16'hA000);
    expectSamples(5, 16'hA000, 3);
    applyStimulus(5, 3);
    runUntilDone(300);
    repeat (4) stepCycle();
    checkOutput("p3_read_rst", 32'(readRstCnt), 32'd2);
    checkOutput("p3_marks", 32'(markCnt), 32'd1);
    checkOutput("p3_outputs", 32'(hsCnt), 32'd15);
    checkOutput("p3_lasts", 32'(lastCnt), 32'd3);
    checkOutput("p3_passes_seen", 32'(expPass), 32'd3);
    checkOutput("p3_done_cnt", 32'(doneCnt), 32'd1);

    // Downstream stall of 20 cycles after two outputs
    $display("[TB] downstream stall");
    clearStats();
    loadFifo(8, 16'hB000);
    expectSamples(8, 16'hB000, 1);
    applyStimulus(8, 1);
    c = 0;
    while (hsCnt < 2 && c < 50) begin stepCycle(); c++; end
    checkOutput("stall_reach", 32'(hsCnt), 32'd2);
    bus.i_data_rdy = 1'b0;
    repeat (20) stepCycle();
    checkOutput("stall_outstanding", 32'(outstanding), 32'd4);
    checkOutput("stall_head", 32'({bus.o_data_vld, bus.o_data}), 32'h1B002);
    bus.i_data_rdy = 1'b1;
    runUntilDone(100);
    checkOutput("stall_max_outstanding", 32'(maxOutstanding), 32'd4);
    checkOutput("stall_unstable", 32'(unstableCnt), 32'd0);
    checkOutput("stall_outputs", 32'(hsCnt), 32'd8);
    checkOutput("stall_left", 32'(expQ.size()), 32'd0);

    // FIFO runs empty after two samples and refills ten cycles later
    $display("[TB] empty fifo");
    clearStats();
    loadFifo(2, 16'hC000);
    expectSamples(5, 16'hC000, 1);
    applyStimulus(5, 1);
    c = 0;
    while (popCnt < 2 && c < 30) begin stepCycle(); c++; end
    popsBefore = popCnt;
    repeat (10) stepCycle();
    checkOutput("empty_no_pops", 32'(popCnt - popsBefore), 32'd0);
    checkOutput("empty_still_busy", 32'(bus.o_busy), 32'd1);
    pushFifo(16'hC002); pushFifo(16'hC003); pushFifo(16'hC004);
    runUntilDone(100);
    checkOutput("empty_pop_while_empty", 32'(popWhileEmpty), 32'd0);
    checkOutput("empty_pops", 32'(popCnt), 32'd5);
    checkOutput("empty_outputs", 32'(hsCnt), 32'd5);

    // Abort with three reads in flight
    $display("[TB] abort");
    clearStats();
    loadFifo(5, 16'hD000);
    curN = 5;
    applyStimulus(5, 1);
    c = 0;
    while (popCnt < 3 && c < 30) begin stepCycle(); c++; end
    bus.i_abort = 1'b1;
    stepCycle();
    bus.i_abort = 1'b0;
    c = 0;
    while (bus.o_busy && c < 20) begin stepCycle(); c++; end
    returnsLeft = 0;
    for (int k = 0; k < LAT; k++) if (pipeVld[k]) returnsLeft++;
    checkOutput("abort_idle_delay", 32'(c), 32'd2);
    checkOutput("abort_returns_left", 32'(returnsLeft), 32'd0);
    repeat (4) stepCycle();
    checkOutput("abort_pops", 32'(popCnt), 32'd3);
    checkOutput("abort_data_vld", 32'(dataVldCnt), 32'd0);
    checkOutput("abort_done", 32'(doneCnt), 32'd0);

    // Clean job after abort
    clearStats();
    loadFifo(3, 16'hE000);
    expectSamples(3, 16'hE000, 1);
    applyStimulus(3, 1);
    runUntilDone(100);
    checkOutput("restart_outputs", 32'(hsCnt), 32'd3);
    checkOutput("restart_done", 32'(doneCnt), 32'd1);

    // Zero-length jobs and ignored controls
    $display("[TB] degenerate jobs");
    clearStats();
    loadFifo(4, 16'hF000);
    applyStimulus(0, 2);
    repeat (4) stepCycle();
    checkOutput("zero_n_pops", 32'(popCnt), 32'd0);
    checkOutput("zero_n_marks", 32'(markCnt), 32'd0);
    checkOutput("zero_n_done", 32'(doneCnt), 32'd1);
    checkOutput("zero_n_busy", 32'(busyCnt), 32'd0);
    clearStats();
    applyStimulus(3, 0);
    repeat (4) stepCycle();
    checkOutput("zero_p_pops_done", 32'({popCnt[7:0], doneCnt[7:0], busyCnt[7:0]}), 32'h000100);
    clearStats();
    bus.i_abort = 1'b1;
    stepCycle();
    bus.i_abort = 1'b0;
    repeat (3) stepCycle();
    checkOutput("idle_abort_ignored", 32'({busyCnt[7:0], doneCnt[7:0]}), 32'd0);

    // Reset in the middle of a job
    $display("[TB] reset mid job");
    clearStats();
    loadFifo(5, 16'h1000);
    applyStimulus(5, 1);
    repeat (4) stepCycle();
    checkOutput("midrst_busy_before", 32'(bus.o_busy), 32'd1);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("midrst_outputs", 32'({bus.o_busy, bus.o_pop, bus.o_data_vld, bus.o_done}), 32'd0);
    rst_n = 1'b1;
    clearStats();
    repeat (5) stepCycle();
    checkOutput("midrst_quiet", 32'({busyCnt[7:0], popCnt[7:0], dataVldCnt[7:0]}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
